// File: rtl/z88_ps2_rx.sv
// PS/2 receiver: sync + glitch filter + deframer into a FWFT FIFO; code_valid 2 clk after the stop-bit fall event.
// Full FIFO drops new bytes with an overflow pulse; Z88_PS2_PREFIX_EN folds E0/F0 prefixes into ext/brk.
module z88_ps2_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000,
   parameter int FIFO_AW    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       ps2dat,
   output logic [7:0] code,
   output logic       ext,
   output logic       brk,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overflow
);

   localparam int FW    = $clog2(FILTER_LEN + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int DEPTH = 1 << FIFO_AW;
`ifdef Z88_PS2_PREFIX_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t            state, state_nxt;
   logic              clk_s1, clk_s2, dat_s1, dat_s2;
   logic              clk_filt, filt_q, fall;
   logic [FW-1:0]     fcnt;
   logic [TW-1:0]     tcnt;
   logic              timeout;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              par_ok;
   logic              deliver, perr_nxt, ferr_nxt;
   logic              push_q;
   logic [EW-1:0]     push_dat;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     head;
   logic [FIFO_AW:0]  wr_ptr, rd_ptr;
   logic              empty, full, pop, wr_en;
`ifdef Z88_PS2_PREFIX_EN
   logic              ext_pend, brk_pend;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2dat;
         dat_s2 <= dat_s1;
      end
   end

   // The filtered clock only follows after FILTER_LEN consecutive disagreeing cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_filt <= 1'b1;
         filt_q   <= 1'b1;
         fcnt     <= '0;
      end else begin
         filt_q <= clk_filt;
         if (clk_s2 == clk_filt) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            fcnt     <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   assign fall    = filt_q & ~clk_filt;
   assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      deliver   = 1'b0;
      perr_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      if (timeout) begin
         state_nxt = IDLE;
         ferr_nxt  = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (dat_s2) ferr_nxt  = 1'b1;
               else        state_nxt = DATA;
            end
            DATA: begin
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               if (!dat_s2)     ferr_nxt = 1'b1;
               else if (!par_ok) perr_nxt = 1'b1;
               else             deliver  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt       <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_ok     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= perr_nxt;
         frame_err  <= ferr_nxt;
         if (fall || (state != IDLE && state_nxt == IDLE))
            tcnt <= '0;
         else if (state != IDLE)
            tcnt <= tcnt + 1'b1;
         if (fall && !timeout) begin
            case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_ok <= ^{shreg, dat_s2};
               default: ;
            endcase
         end
      end
   end

   // Delivered byte is staged one cycle before the FIFO write.
   always_ff @(posedge clk) begin
      if (reset) begin
         push_q   <= 1'b0;
         push_dat <= '0;
`ifdef Z88_PS2_PREFIX_EN
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
`endif
      end else begin
`ifdef Z88_PS2_PREFIX_EN
         push_q <= 1'b0;
         if (perr_nxt || ferr_nxt) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (deliver) begin
            if (shreg == 8'hE0) begin
               ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
               brk_pend <= 1'b1;
            end else begin
               push_q   <= 1'b1;
               push_dat <= {ext_pend, brk_pend, shreg};
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end
         end
`else
         push_q <= deliver;
         if (deliver) push_dat <= shreg;
`endif
      end
   end

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign code_valid = ~empty;
   assign pop        = code_valid & code_ready;
   assign wr_en      = push_q & (~full | pop);
   assign overflow   = push_q & full & ~pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
   end

   assign head = mem[rd_ptr[FIFO_AW-1:0]];

   // Head is masked so outputs read 0 while the FIFO is empty.
`ifdef Z88_PS2_PREFIX_EN
   assign code = code_valid ? head[7:0] : 8'h00;
   assign ext  = code_valid & head[9];
   assign brk  = code_valid & head[8];
`else
   assign code = code_valid ? head : 8'h00;
   assign ext  = 1'b0;
   assign brk  = 1'b0;
`endif

endmodule

// File: tb/tb_z88_ps2_rx.sv
// Bench for z88_ps2_rx: directed table, hand-written corner sequences and random frames against a queue model.
module tb_z88_ps2_rx;

   localparam int FL    = 8;
   localparam int TO    = 3000;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int HP    = 30;

   logic       clk = 1'b0;
   logic       reset, ps2clk, ps2dat, code_ready;
   logic [7:0] code;
   logic       ext, brk, code_valid, parity_err, frame_err, overflow;

   int checks = 0, errors = 0;
   int n_perr = 0, n_ferr = 0, n_ovf = 0;

   always #5 clk = ~clk;

   z88_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_AW(AW)) dut (
      .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2dat(ps2dat),
      .code(code), .ext(ext), .brk(brk), .code_valid(code_valid),
      .code_ready(code_ready), .parity_err(parity_err),
      .frame_err(frame_err), .overflow(overflow)
   );

   always @(negedge clk) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode 1: check code_valid latency at the stop bit; mode 2: pop exactly in the push cycle
   task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs,
                             input int nbits, input int glitch_bit, input int mode);
      logic [10:0] fr;
      fr = {~bs, (~^b) ^ bp, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2dat = fr[i];
         if (i == glitch_bit) begin
            tick(5);
            ps2clk = 1'b0;
            tick(FL - 1);
            ps2clk = 1'b1;
            tick(HP - 5 - (FL - 1));
         end else begin
            tick(HP);
         end
         ps2clk = 1'b0;
         for (int k = 1; k <= HP; k++) begin
            tick(1);
            if (mode == 1 && i == 10) begin
               if (k == FL + 3) chk("lat_before", int'(code_valid), 0);
               if (k == FL + 4) chk("lat_valid", int'(code_valid), 1);
            end
            if (mode == 2 && i == 10) begin
               if (k == FL + 3) code_ready = 1'b1;
               if (k == FL + 4) code_ready = 1'b0;
            end
         end
         ps2clk = 1'b1;
      end
      ps2dat = 1'b1;
      tick(HP);
   endtask

   task automatic pop_expect(input logic [7:0] c, input bit e, input bit bk, input string nm);
      chk({nm, "_vld"},  int'(code_valid), 1);
      chk({nm, "_code"}, int'(code), int'(c));
      chk({nm, "_ext"},  int'(ext), int'(e));
      chk({nm, "_brk"},  int'(brk), int'(bk));
      code_ready = 1'b1;
      tick(1);
      code_ready = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_code"}, int'(code), 0);
      chk({nm, "_ext"},  int'(ext), 0);
      chk({nm, "_brk"},  int'(brk), 0);
      chk({nm, "_vld"},  int'(code_valid), 0);
      chk({nm, "_perr"}, int'(parity_err), 0);
      chk({nm, "_ferr"}, int'(frame_err), 0);
      chk({nm, "_ovf"},  int'(overflow), 0);
   endtask

   // Reference model: what the FIFO should hold and which pulses each frame should cause.
   logic [9:0] mq[$];
   bit m_ext, m_brk;
   int m_perr, m_ferr, m_ovf;

   task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
      bit deliver_it;
      bit push_it;
      deliver_it = 1'b0;
      push_it = 1'b0;
      if (bs) begin
         m_ferr++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (bp) begin
         m_perr++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         deliver_it = 1'b1;
      end
      if (deliver_it) begin
`ifdef Z88_PS2_PREFIX_EN
         if (b == 8'hE0)      m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else                 push_it = 1'b1;
`else
         push_it = 1'b1;
`endif
      end
      if (push_it) begin
         if (mq.size() == DEPTH) m_ovf++;
         else mq.push_back({m_ext, m_brk, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] b;
      bit         bp;
      bit         bs;
      bit         exp_push;
      int         exp_perr;
      int         exp_ferr;
   } vec_t;

   initial begin
      vec_t tbl[6];
      logic [7:0] seq5[5];
      int p0, f0, o0;
      logic [9:0] ent;

      tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[2] = '{8'h1B, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[3] = '{8'h29, 1'b0, 1'b1, 1'b0, 0, 1};
      tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 0, 1};
      seq5 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

      reset = 1'b1; ps2clk = 1'b1; ps2dat = 1'b1; code_ready = 1'b0;
      tick(3);
      chk_idle_outputs("reset");
      reset = 1'b0;
      tick(5);

      // Basic frame with exact delivery latency.
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1);
      pop_expect(8'h1C, 1'b0, 1'b0, "t1");
      chk("t1_empty", int'(code_valid), 0);

      // Short clock glitches must not register as edges.
      f0 = n_ferr;
      ps2clk = 1'b0;
      tick(FL - 1);
      ps2clk = 1'b1;
      tick(HP);
      chk("glitch_idle_ferr", n_ferr - f0, 0);
      chk("glitch_idle_vld", int'(code_valid), 0);
      send_frame(8'h5A, 1'b0, 1'b0, 11, 3, 0);
      chk("glitch_data_ferr", n_ferr - f0, 0);
      pop_expect(8'h5A, 1'b0, 1'b0, "glitch_data");

      // A lone fall with data high while idle is a bad start bit.
      f0 = n_ferr;
      ps2dat = 1'b1;
      ps2clk = 1'b0;
      tick(HP);
      ps2clk = 1'b1;
      tick(HP);
      chk("badstart_ferr", n_ferr - f0, 1);
      chk("badstart_vld", int'(code_valid), 0);

      for (int i = 0; i < 6; i++) begin
         p0 = n_perr;
         f0 = n_ferr;
         send_frame(tbl[i].b, tbl[i].bp, tbl[i].bs, 11, -1, 0);
         chk($sformatf("tbl%0d_perr", i), n_perr - p0, tbl[i].exp_perr);
         chk($sformatf("tbl%0d_ferr", i), n_ferr - f0, tbl[i].exp_ferr);
         chk($sformatf("tbl%0d_vld", i), int'(code_valid), int'(tbl[i].exp_push));
         if (tbl[i].exp_push) pop_expect(tbl[i].b, 1'b0, 1'b0, $sformatf("tbl%0d", i));
      end

      // Prefix bytes.
      send_frame(8'hE0, 1'b0, 1'b0, 11, -1, 0);
      send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 0);
      send_frame(8'h75, 1'b0, 1'b0, 11, -1, 0);
`ifdef Z88_PS2_PREFIX_EN
      pop_expect(8'h75, 1'b1, 1'b1, "pfx");
`else
      pop_expect(8'hE0, 1'b0, 1'b0, "raw_e0");
      pop_expect(8'hF0, 1'b0, 1'b0, "raw_f0");
      pop_expect(8'h75, 1'b0, 1'b0, "raw_75");
`endif
      chk("pfx_empty", int'(code_valid), 0);

      // Stalled frame times out.
      f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b0, 5, -1, 0);
      tick(TO + 10);
      chk("timeout_ferr", n_ferr - f0, 1);
      chk("timeout_vld", int'(code_valid), 0);
      send_frame(8'h29, 1'b0, 1'b0, 11, -1, 0);
      chk("timeout_after_ferr", n_ferr - f0, 1);
      pop_expect(8'h29, 1'b0, 1'b0, "timeout_next");

      // Overflow on the fifth byte.
      for (int i = 0; i < 5; i++) begin
         o0 = n_ovf;
         send_frame(seq5[i], 1'b0, 1'b0, 11, -1, 0);
         chk($sformatf("ovf%0d", i), n_ovf - o0, (i == 4) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) pop_expect(seq5[i], 1'b0, 1'b0, $sformatf("ovf_pop%0d", i));
      chk("ovf_empty", int'(code_valid), 0);

      // Push and pop in the same cycle while full.
      for (int i = 0; i < 4; i++) send_frame(seq5[i], 1'b0, 1'b0, 11, -1, 0);
      o0 = n_ovf;
      send_frame(seq5[4], 1'b0, 1'b0, 11, -1, 2);
      chk("full_pushpop_ovf", n_ovf - o0, 0);
      for (int i = 1; i < 5; i++) pop_expect(seq5[i], 1'b0, 1'b0, $sformatf("pp_pop%0d", i));
      chk("pp_empty", int'(code_valid), 0);

      // Ready while empty is harmless.
      code_ready = 1'b1;
      tick(5);
      code_ready = 1'b0;
      chk("rdy_empty_vld", int'(code_valid), 0);
      send_frame(8'h11, 1'b0, 1'b0, 11, -1, 0);
      pop_expect(8'h11, 1'b0, 1'b0, "rdy_empty");

      // Reset mid-frame with an entry queued.
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 0);
      send_frame(8'h33, 1'b0, 1'b0, 4, -1, 0);
      reset = 1'b1;
      tick(1);
      chk_idle_outputs("midreset");
      reset = 1'b0;
      tick(3);
      send_frame(8'h29, 1'b0, 1'b0, 11, -1, 0);
      pop_expect(8'h29, 1'b0, 1'b0, "midreset_next");
      chk("midreset_empty", int'(code_valid), 0);

      // Random frames against the model.
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      mq.delete();
      m_ext = 1'b0; m_brk = 1'b0; m_perr = 0; m_ferr = 0; m_ovf = 0;
      for (int it = 0; it < 20; it++) begin
         logic [7:0] b;
         bit bp, bs;
         int sel, mp, mf, mo, k;
         sel = int'($urandom_range(0, 9));
         b  = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 7) == 0);
         bs = ($urandom_range(0, 9) == 0);
         p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
         mp = m_perr; mf = m_ferr; mo = m_ovf;
         send_frame(b, bp, bs, 11, -1, 0);
         model_frame(b, bp, bs);
         chk($sformatf("rnd%0d_perr", it), n_perr - p0, m_perr - mp);
         chk($sformatf("rnd%0d_ferr", it), n_ferr - f0, m_ferr - mf);
         chk($sformatf("rnd%0d_ovf", it), n_ovf - o0, m_ovf - mo);
         k = int'($urandom_range(0, mq.size()));
         for (int j = 0; j < k; j++) begin
            ent = mq.pop_front();
            pop_expect(ent[7:0], ent[9], ent[8], $sformatf("rnd%0d", it));
         end
      end
      while (mq.size() > 0) begin
         ent = mq.pop_front();
         pop_expect(ent[7:0], ent[9], ent[8], "rnd_drain");
      end
      chk("rnd_empty", int'(code_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
